id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that directly feeds the ALU.
- Captures decoded operands and control on each clock, then drives the ALU's aluin1, aluin2, aluco and alu_shift inputs.
- Resolves data hazards in EX by forwarding results from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble per hazard.

Parameters:
- FORWARD_EN, 1, 1 enables EX/MEM and MEM/WB forwarding; 0 always uses the registered operands.
- HAZARD_EN, 1, 1 enables load-use detection and bubble insertion; 0 ties load_use_hazard to 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous reset, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data  in  32  register-file read data for rs
- id_rt_data  in  32  register-file read data for rt
- id_imm  in  32  sign-extended immediate
- id_shamt  in  5  shift amount field
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_aluco  in  4  ALU control code
- id_alusrc  in  1  1 selects immediate as second operand
- id_regdst  in  1  1 selects rd as destination, 0 selects rt
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  downstream control
- stall  in  1  hold all EX registers
- flush  in  1  replace EX contents with a bubble
- exmem_regwrite  in  1  EX/MEM writes the register file
- exmem_rd  in  5  EX/MEM destination
- exmem_result  in  32  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB writes the register file
- memwb_rd  in  5  MEM/WB destination
- memwb_result  in  32  MEM/WB writeback value
- ex_valid  out  1  EX slot holds a real instruction
- aluin1, aluin2  out  32 each  ALU operands
- aluco  out  4  ALU control
- alu_shift  out  5  ALU shift amount
- ex_store_data  out  32  forwarded rt value for stores
- ex_dest  out  5  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control
- load_use_hazard  out  1  decode must stall one cycle

Behaviour:
- Reset (asynchronous, active-high): every EX register clears to 0. With no reset-time forwarding this yields:
  - ex_valid=0, aluco=0, alu_shift=0, ex_dest=0, all control outputs 0
  - aluin1=0, aluin2=0, ex_store_data=0
- Register update priority on each rising clk edge, highest first:
  - flush: load a bubble (all fields 0, ex_valid=0).
  - stall: hold all fields.
  - load_use_hazard: load a bubble.
  - otherwise: capture the id_* fields, with ex_dest = id_regdst ? id_rd : id_rt.
- Capture rule: when id_valid=0, the block captures a bubble regardless of the other id_* inputs.
- Bubble encoding: all control fields zero. A bubble must never write a register or memory.
- Latency: decode inputs appear on outputs one cycle after capture.
- Forwarding (combinational, from registered rs/rt):
  - fwdA selects exmem_result when exmem_regwrite=1, exmem_rd!=0 and exmem_rd==ex_rs.
  - Otherwise fwdA selects memwb_result under the same conditions for MEM/WB.
  - Otherwise fwdA uses the registered rs_data.
  - fwdB is computed the same way on ex_rt.
  - When both sources match, EX/MEM wins.
  - Register 0 is never forwarded.
- Operand outputs:
  - aluin1 = fwdA.
  - aluin2 = ex_alusrc ? ex_imm : fwdB.
  - ex_store_data = fwdB, always, including when alusrc=1.
  - alu_shift = registered shamt. aluco = registered aluco.
- load_use_hazard (combinational) asserts when all of the following hold:
  - ex_valid=1 and ex_memread=1
  - ex_dest!=0
  - id_valid=1
  - ex_dest==id_rs, or ex_dest==id_rt
- Hazard timing:
  - load_use_hazard deasserts in the following cycle, because EX then holds a bubble.
  - Upstream must hold IF/ID while load_use_hazard=1.
- Stall together with a hazard: the block holds, and the hazard is re-evaluated next cycle.
- Flush wins over both stall and hazard.
- Reset asserted mid-operation: outputs clear immediately, without waiting for clk.

Test Plan:
- Reset then load: assert reset; release; load id add (aluco=2, rs_data=8, rt_data=4, alusrc=0, regdst=1, rd=3) -> one cycle later aluin1=8, aluin2=4, aluco=2, ex_dest=3, ex_regwrite=1, ex_valid=1.
- EX/MEM forwarding and priority: EX rs=5; exmem_regwrite=1, exmem_rd=5, exmem_result=0x11; memwb_rd=5, memwb_result=0x22 -> aluin1=0x11. Deassert exmem_regwrite -> aluin1=0x22. Set exmem_rd=0 with exmem_regwrite=1 -> no forward from EX/MEM.
- Load-use: EX holds lw (memread=1, ex_dest=7); ID holds instruction with id_rt=7 -> load_use_hazard=1. Next edge: ex_valid=0, all controls 0, hazard=0. Instruction captured on the following edge.
- Immediate and shift: id_alusrc=1, id_imm=0xFFFFFFFC, id_rt_data=9, id_shamt=31, id_aluco=14 -> aluin2=0xFFFFFFFC, ex_store_data=9, alu_shift=31.
- Stall/flush priority: stall=1 for 2 cycles with changing id_* -> outputs unchanged. Assert stall=1 and flush=1 together -> bubble loaded.
- Asynchronous reset: assert reset between clock edges while EX is valid -> ex_valid, ex_regwrite and aluco go to 0 before the next clk edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle between decode, the ID/EX register and the ALU: decode fields,
// stall/flush, forwarding sources in, registered EX operands and control out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32
);
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_shamt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [3:0]        id_aluco;
  logic              id_alusrc;
  logic              id_regdst;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_memtoreg;
  logic              stall;
  logic              flush;
  logic              exmem_regwrite;
  logic [4:0]        exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_regwrite;
  logic [4:0]        memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              ex_valid;
  logic [DATA_W-1:0] aluin1;
  logic [DATA_W-1:0] aluin2;
  logic [3:0]        aluco;
  logic [4:0]        alu_shift;
  logic [DATA_W-1:0] ex_store_data;
  logic [4:0]        ex_dest;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              load_use_hazard;

  modport master (
    output id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_rd,
           id_aluco, id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite,
           id_memtoreg, stall, flush, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  ex_valid, aluin1, aluin2, aluco, alu_shift, ex_store_data, ex_dest,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_hazard
  );

  modport slave (
    input  id_valid, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_rd,
           id_aluco, id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite,
           id_memtoreg, stall, flush, exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output ex_valid, aluin1, aluin2, aluco, alu_shift, ex_store_data, ex_dest,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_hazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB operand
// forwarding and one-bubble load-use hazard insertion.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter bit FORWARD_EN = 1'b1,
  parameter bit HAZARD_EN  = 1'b1
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic                     valid;
    logic [4:0]               rs;
    logic [4:0]               rt;
    logic signed [DATA_W-1:0] rs_data;
    logic signed [DATA_W-1:0] rt_data;
    logic signed [DATA_W-1:0] imm;
    logic [4:0]               shamt;
    logic [3:0]               aluco;
    logic                     alusrc;
    logic [4:0]               dest;
    logic                     regwrite;
    logic                     memread;
    logic                     memwrite;
    logic                     memtoreg;
  } ex_t;

  ex_t                      ex_q;
  ex_t                      ex_d;
  logic                     load_use_hazard;
  logic signed [DATA_W-1:0] fwd_a;
  logic signed [DATA_W-1:0] fwd_b;

  // EX/MEM is the younger producer, so it is checked first; r0 never forwards.
  function automatic logic signed [DATA_W-1:0] forward_sel(
    input logic [4:0]               src,
    input logic signed [DATA_W-1:0] reg_val,
    input logic                     em_we,
    input logic [4:0]               em_rd,
    input logic signed [DATA_W-1:0] em_val,
    input logic                     mw_we,
    input logic [4:0]               mw_rd,
    input logic signed [DATA_W-1:0] mw_val
  );
    logic signed [DATA_W-1:0] res;
    res = reg_val;
    if (FORWARD_EN && em_we && (em_rd != 5'd0) && (em_rd == src)) begin
      res = em_val;
    end else if (FORWARD_EN && mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
      res = mw_val;
    end
    return res;
  endfunction

  always_comb begin
    load_use_hazard = 1'b0;
    if (HAZARD_EN && ex_q.valid && ex_q.memread && (ex_q.dest != 5'd0) &&
        bus.id_valid && ((ex_q.dest == bus.id_rs) || (ex_q.dest == bus.id_rt))) begin
      load_use_hazard = 1'b1;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.stall) begin
      ex_d = ex_q;
    end else if (load_use_hazard || !bus.id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = 1'b1;
      ex_d.rs       = bus.id_rs;
      ex_d.rt       = bus.id_rt;
      ex_d.rs_data  = bus.id_rs_data;
      ex_d.rt_data  = bus.id_rt_data;
      ex_d.imm      = bus.id_imm;
      ex_d.shamt    = bus.id_shamt;
      ex_d.aluco    = bus.id_aluco;
      ex_d.alusrc   = bus.id_alusrc;
      ex_d.dest     = bus.id_regdst ? bus.id_rd : bus.id_rt;
      ex_d.regwrite = bus.id_regwrite;
      ex_d.memread  = bus.id_memread;
      ex_d.memwrite = bus.id_memwrite;
      ex_d.memtoreg = bus.id_memtoreg;
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_comb begin
    fwd_a = forward_sel(ex_q.rs, ex_q.rs_data, bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result, bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
    fwd_b = forward_sel(ex_q.rt, ex_q.rt_data, bus.exmem_regwrite, bus.exmem_rd,
                        bus.exmem_result, bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.aluin1          = fwd_a;
  assign bus.aluin2          = ex_q.alusrc ? ex_q.imm : fwd_b;
  assign bus.ex_store_data   = fwd_b;
  assign bus.aluco           = ex_q.aluco;
  assign bus.alu_shift       = ex_q.shamt;
  assign bus.ex_dest         = ex_q.dest;
  assign bus.ex_regwrite     = ex_q.regwrite;
  assign bus.ex_memread      = ex_q.memread;
  assign bus.ex_memwrite     = ex_q.memwrite;
  assign bus.ex_memtoreg     = ex_q.memtoreg;
  assign bus.load_use_hazard = load_use_hazard;

endmodule
